// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - back-buffer clear and object rectangle rasteriser
// Clears port B to BG_COLOR, then fills each listed object as a screen-clipped rectangle.

package frame_renderer_pkg;
  typedef logic [23:0] pixel_t;
endpackage

module frame_renderer
  import frame_renderer_pkg::*;
#(
  parameter int     H_RES       = 640,
  parameter int     V_RES       = 480,
  parameter int     MAX_OBJECTS = 64,
  parameter pixel_t BG_COLOR    = '0,
  localparam int    OBJ_AW      = $clog2(MAX_OBJECTS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              next_frame,
  output logic [9:0]        address_b_x,
  output logic [9:0]        address_b_y,
  output pixel_t            write_data_b,
  output logic              write_enable_b,
  input  pixel_t            data_b,
  output logic              object_buffer_read_end,
  output logic [OBJ_AW-1:0] obj_addr,
  input  logic [9:0]        obj_x,
  input  logic [9:0]        obj_y,
  input  logic [9:0]        obj_w,
  input  logic [9:0]        obj_h,
  input  pixel_t            obj_color,
  input  logic              obj_valid,
  input  logic              obj_xor,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LATCH,
    DRAW,
    XOR_RD,
    XOR_WR,
    DONE
  } state_t;

  localparam logic [10:0]       H_END    = 11'(H_RES);
  localparam logic [10:0]       V_END    = 11'(V_RES);
  localparam logic [9:0]        H_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]        V_LAST   = 10'(V_RES - 1);
  localparam logic [OBJ_AW-1:0] OBJ_LAST = OBJ_AW'(MAX_OBJECTS - 1);

  state_t      state;
  pixel_t      wdata;
  pixel_t      color_r;
  logic [9:0]  x_start;
  logic [9:0]  x_last;
  logic [9:0]  y_last;

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [9:0]  x_last_c;
  logic [9:0]  y_last_c;
  logic        skip;
  logic        last_col;
  logic        last_row;
  logic        last_obj;

  // Sums are 11 bits wide so obj_x + obj_w can never wrap past the screen edge.
  always_comb begin
    x_sum    = {1'b0, obj_x} + {1'b0, obj_w};
    y_sum    = {1'b0, obj_y} + {1'b0, obj_h};
    x_last_c = (x_sum > H_END) ? H_LAST : 10'(x_sum - 11'd1);
    y_last_c = (y_sum > V_END) ? V_LAST : 10'(y_sum - 11'd1);
    skip     = (obj_w == 10'd0) || (obj_h == 10'd0) ||
               ({1'b0, obj_x} >= H_END) || ({1'b0, obj_y} >= V_END);
    last_col = (address_b_x == x_last);
    last_row = (address_b_y == y_last);
    last_obj = (obj_addr == OBJ_LAST);
  end

  // Read data arrives in the WR cycle, so the XOR result cannot be registered ahead of it.
  assign write_data_b = (state == XOR_WR) ? (data_b ^ color_r) : wdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                  <= IDLE;
      address_b_x            <= '0;
      address_b_y            <= '0;
      wdata                  <= '0;
      write_enable_b         <= 1'b0;
      object_buffer_read_end <= 1'b0;
      obj_addr               <= '0;
      busy                   <= 1'b0;
      color_r                <= '0;
      x_start                <= '0;
      x_last                 <= '0;
      y_last                 <= '0;
    end else begin
      object_buffer_read_end <= 1'b0;
      case (state)
        IDLE: begin
          if (next_frame) begin
            state          <= CLEAR;
            busy           <= 1'b1;
            address_b_x    <= '0;
            address_b_y    <= '0;
            wdata          <= BG_COLOR;
            write_enable_b <= 1'b1;
          end
        end
        CLEAR: begin
          if (address_b_x == H_LAST) begin
            address_b_x <= '0;
            if (address_b_y == V_LAST) begin
              write_enable_b <= 1'b0;
              obj_addr       <= '0;
              state          <= FETCH;
            end else begin
              address_b_y <= address_b_y + 10'd1;
            end
          end else begin
            address_b_x <= address_b_x + 10'd1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          if (!obj_valid) begin
            state                  <= DONE;
            object_buffer_read_end <= 1'b1;
          end else if (skip) begin
            // A skipped entry at the last index must not wrap the list pointer.
            if (last_obj) begin
              state                  <= DONE;
              object_buffer_read_end <= 1'b1;
            end else begin
              obj_addr <= obj_addr + 1'b1;
              state    <= FETCH;
            end
          end else begin
            color_r     <= obj_color;
            wdata       <= obj_color;
            x_start     <= obj_x;
            x_last      <= x_last_c;
            y_last      <= y_last_c;
            address_b_x <= obj_x;
            address_b_y <= obj_y;
            if (obj_xor) begin
              write_enable_b <= 1'b0;
              state          <= XOR_RD;
            end else begin
              write_enable_b <= 1'b1;
              state          <= DRAW;
            end
          end
        end
        XOR_RD: begin
          write_enable_b <= 1'b1;
          state          <= XOR_WR;
        end
        DRAW, XOR_WR: begin
          if (last_col && last_row) begin
            write_enable_b <= 1'b0;
            if (last_obj) begin
              state                  <= DONE;
              object_buffer_read_end <= 1'b1;
            end else begin
              obj_addr <= obj_addr + 1'b1;
              state    <= FETCH;
            end
          end else begin
            if (last_col) begin
              address_b_x <= x_start;
              address_b_y <= address_b_y + 10'd1;
            end else begin
              address_b_x <= address_b_x + 10'd1;
            end
            if (state == XOR_WR) begin
              write_enable_b <= 1'b0;
              state          <= XOR_RD;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
